// File: rtl/wb_pkg.sv
// Shared types for the write-back port arbiter: FSM states, slot sources and a queued entry.
package wb_pkg;

  localparam int WB_B          = 32;
  localparam int WB_D          = 5;
  localparam int WB_DEPTH      = 4;
  localparam int WB_STARVE_MAX = 8;
  localparam int LVL_W         = $clog2(WB_DEPTH + 1);

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } wb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_AUX  = 2'd2
  } wb_src_t;

  typedef struct packed {
    logic [WB_D-1:0] waddr;
    logic [WB_B-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for long-latency results; exports per-entry valid/address for hazard lookup.
module wb_fifo #(
  parameter int B     = 32,
  parameter int D     = 5,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [D-1:0]                 push_waddr,
  input  logic [B-1:0]                 push_wdata,
  input  logic                         pop,
  output logic [D-1:0]                 head_waddr,
  output logic [B-1:0]                 head_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         empty,
  output logic                         full,
  output logic [DEPTH-1:0]             ent_valid,
  output logic [DEPTH-1:0][D-1:0]      ent_waddr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [LW-1:0]           level_q;
  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH-1:0][D-1:0] addr_q;
  logic [DEPTH-1:0][B-1:0] data_q;
  logic                    push_ok;
  logic                    pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      valid_q <= '0;
      addr_q  <= '0;
    end else begin
      if (pop_ok) begin
        rd_ptr          <= rd_ptr + 1'b1;
        valid_q[rd_ptr] <= 1'b0;
      end
      if (push_ok) begin
        wr_ptr          <= wr_ptr + 1'b1;
        valid_q[wr_ptr] <= 1'b1;
        addr_q[wr_ptr]  <= push_waddr;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Payload needs no reset: it is only observed behind valid_q.
  always_ff @(posedge clk) begin
    if (push_ok) data_q[wr_ptr] <= push_wdata;
  end

  assign head_waddr = addr_q[rd_ptr];
  assign head_wdata = data_q[rd_ptr];
  assign level      = level_q;
  assign ent_valid  = valid_q;
  assign ent_waddr  = addr_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back first, queued long-latency results in idle
// slots, starvation-forced one-cycle stall. Optional macro WB_BYPASS_EN: direct aux path when idle.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int B          = WB_B,
  parameter int D          = WB_D,
  parameter int DEPTH      = WB_DEPTH,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pipe_we,
  input  logic [D-1:0]               pipe_waddr,
  input  logic [B-1:0]               pipe_wdata,
  input  logic                       aux_valid,
  output logic                       aux_ready,
  input  logic [D-1:0]               aux_waddr,
  input  logic [B-1:0]               aux_wdata,
  input  logic [D-1:0]               chk_addr,
  output logic                       chk_pending,
  output logic                       stall_pipe,
  output logic                       rf_we,
  output logic [D-1:0]               rf_waddr,
  output logic [B-1:0]               rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  wb_state_t               state_q, state_d;
  wb_src_t                 src;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    push, pop;
  logic [D-1:0]            sel_waddr;
  logic [B-1:0]            sel_wdata;
  logic [D-1:0]            head_waddr;
  logic [B-1:0]            head_wdata;
  logic                    empty, full;
  logic [DEPTH-1:0]        ent_valid;
  logic [DEPTH-1:0][D-1:0] ent_waddr;
  logic                    hit;

  // Handshake: an aux result transfers on a cycle where aux_valid && aux_ready; the producer holds
  // its data while aux_ready is low. aux_ready depends only on FIFO occupancy, never on aux_valid.
  assign aux_ready = !full;

  wb_fifo #(.B(B), .D(D), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_waddr (aux_waddr),
    .push_wdata (aux_wdata),
    .pop        (pop),
    .head_waddr (head_waddr),
    .head_wdata (head_wdata),
    .level      (fifo_level),
    .empty      (empty),
    .full       (full),
    .ent_valid  (ent_valid),
    .ent_waddr  (ent_waddr)
  );

  always_comb begin
    src       = SRC_NONE;
    sel_waddr = head_waddr;
    sel_wdata = head_wdata;
    pop       = 1'b0;
    push      = aux_valid && aux_ready;
    if (state_q == FORCE) begin
      // Pipeline is frozen this cycle; it re-presents its write next cycle.
      if (!empty) begin
        src = SRC_AUX;
        pop = 1'b1;
      end
    end else if (pipe_we) begin
      src       = SRC_PIPE;
      sel_waddr = pipe_waddr;
      sel_wdata = pipe_wdata;
    end else if (!empty) begin
      src = SRC_AUX;
      pop = 1'b1;
    end
`ifdef WB_BYPASS_EN
    else if (aux_valid) begin
      src       = SRC_AUX;
      sel_waddr = aux_waddr;
      sel_wdata = aux_wdata;
      push      = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = NORMAL;
    cnt_d   = (pop || empty) ? '0 : cnt_q + 1'b1;
    if (state_q == NORMAL && !empty && !pop && cnt_q == CW'(STARVE_MAX - 1)) begin
      state_d = FORCE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_pipe = (state_q == FORCE);

  // Writes to r0 still consume their slot (and their FIFO entry) but never reach the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= (src != SRC_NONE) && (sel_waddr != '0);
      if (src != SRC_NONE) begin
        rf_waddr <= sel_waddr;
        rf_wdata <= sel_wdata;
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_waddr[i] == chk_addr) hit = 1'b1;
    end
  end

  assign chk_pending = hit && (chk_addr != '0);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: scoreboard of expected regfile writes plus directed checks.
module tb_wb_port_arbiter;

  localparam int B = 32;
  localparam int D = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pipe_we = 1'b0;
  logic [D-1:0] pipe_waddr = '0;
  logic [B-1:0] pipe_wdata = '0;
  logic         aux_valid = 1'b0;
  logic         aux_ready;
  logic [D-1:0] aux_waddr = '0;
  logic [B-1:0] aux_wdata = '0;
  logic [D-1:0] chk_addr = '0;
  logic         chk_pending;
  logic         stall_pipe;
  logic         rf_we;
  logic [D-1:0] rf_waddr;
  logic [B-1:0] rf_wdata;
  logic [2:0]   fifo_level;

  logic [D+B-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  wb_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_we     (pipe_we),
    .pipe_waddr  (pipe_waddr),
    .pipe_wdata  (pipe_wdata),
    .aux_valid   (aux_valid),
    .aux_ready   (aux_ready),
    .aux_waddr   (aux_waddr),
    .aux_wdata   (aux_wdata),
    .chk_addr    (chk_addr),
    .chk_pending (chk_pending),
    .stall_pipe  (stall_pipe),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fifo_level  (fifo_level)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [D-1:0] a, input logic [B-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic idle_inputs();
    pipe_we   = 1'b0;
    aux_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every regfile write must match the oldest expected write.
  always @(negedge clk) begin
    logic [D+B-1:0] e;
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(rf_waddr), 64'(e[D+B-1:B]));
        check("wr_data", 64'(rf_wdata), 64'(e[B-1:0]));
      end
    end
  end

  // Decode never issues a pipe write to a register still pending in the FIFO.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && pipe_we && pipe_waddr != '0 && chk_addr == pipe_waddr)
      check("raw_hazard", 64'(chk_pending), 64'd0);
  end

  initial begin
    int pv, stall_cnt, stall_at, seen;
    logic [B-1:0] rnd;
    logic [D+B-1:0] aux_exp[$];

    // Reset state
    repeat (2) cyc();
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    check("rst_stall", 64'(stall_pipe), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ready", 64'(aux_ready), 64'd1);
    rst_n = 1'b1;
    cyc();

    // 1: single pipe write, one-cycle latency
    pipe_we = 1'b1; pipe_waddr = 5; pipe_wdata = 32'hDEADBEEF; chk_addr = 5;
    push_exp(5, 32'hDEADBEEF);
    cyc();
    idle_inputs();
    check("t1_we", 64'(rf_we), 64'd1);
    cyc();
    check("t1_we_off", 64'(rf_we), 64'd0);

    // 2: aux write with pipe idle, hazard query until pop
    aux_valid = 1'b1; aux_waddr = 7; aux_wdata = 32'h11; chk_addr = 7;
    push_exp(7, 32'h11);
    cyc();
    aux_valid = 1'b0;
`ifdef WB_BYPASS_EN
    check("t2_we", 64'(rf_we), 64'd1);
    check("t2_pend", 64'(chk_pending), 64'd0);
    check("t2_lvl", 64'(fifo_level), 64'd0);
`else
    check("t2_we_early", 64'(rf_we), 64'd0);
    check("t2_pend", 64'(chk_pending), 64'd1);
    check("t2_lvl", 64'(fifo_level), 64'd1);
    cyc();
    check("t2_we", 64'(rf_we), 64'd1);
    check("t2_pend_clr", 64'(chk_pending), 64'd0);
    check("t2_lvl_clr", 64'(fifo_level), 64'd0);
`endif
    cyc();

    // 3: continuous pipe traffic starves one aux entry until the forced stall
    pv = 0; stall_cnt = 0; stall_at = -1;
    rnd = $urandom;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) cyc();
      if (stall_pipe) begin
        stall_cnt++;
        stall_at = i;
        push_exp(3, 32'h33);
      end else begin
        push_exp(10, rnd + 32'(pv));
      end
      pipe_we = 1'b1; pipe_waddr = 10; pipe_wdata = rnd + 32'(pv); chk_addr = 10;
      if (!stall_pipe) pv++;
      aux_valid = (i == 0); aux_waddr = 3; aux_wdata = 32'h33;
    end
    cyc();
    idle_inputs();
    check("t3_stall_cnt", 64'(stall_cnt), 64'd1);
    check("t3_stall_at", 64'(stall_at), 64'd9);
    wait_drain(10);
    check("t3_lvl", 64'(fifo_level), 64'd0);

    // 4: fill the FIFO while the pipe is busy; an extra aux request is refused
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k == 4) begin
        check("t4_ready", 64'(aux_ready), 64'd0);
        check("t4_lvl_full", 64'(fifo_level), 64'd4);
      end
      pipe_we = 1'b1; pipe_waddr = 12; pipe_wdata = 32'h400 + 32'(k); chk_addr = 12;
      push_exp(12, 32'h400 + 32'(k));
      aux_valid = 1'b1; aux_waddr = 5'(20 + k); aux_wdata = 32'h4A0 + 32'(k);
      if (k < 4) aux_exp.push_back({5'(20 + k), 32'h4A0 + 32'(k)});
    end
    cyc();
    idle_inputs();
    check("t4_ready_hold", 64'(aux_ready), 64'd0);
    check("t4_lvl_hold", 64'(fifo_level), 64'd4);
    foreach (aux_exp[j]) exp_q.push_back(aux_exp[j]);
    wait_drain(12);
    check("t4_lvl_empty", 64'(fifo_level), 64'd0);

    // 5: writes to r0 are suppressed, the aux entry is still consumed
    cyc();
    pipe_we = 1'b1; pipe_waddr = 0; pipe_wdata = 32'h500; chk_addr = 0;
    aux_valid = 1'b1; aux_waddr = 0; aux_wdata = 32'h55;
    cyc();
    idle_inputs();
    check("t5_we_pipe", 64'(rf_we), 64'd0);
    check("t5_lvl", 64'(fifo_level), 64'd1);
    cyc();
    check("t5_we_aux", 64'(rf_we), 64'd0);
    check("t5_lvl_pop", 64'(fifo_level), 64'd0);

    // 6: asynchronous reset while stalled with three queued entries
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (stall_pipe) begin
        seen = 1;
        break;
      end
      pipe_we = 1'b1; pipe_waddr = 14; pipe_wdata = 32'h600 + 32'(i); chk_addr = 14;
      push_exp(14, 32'h600 + 32'(i));
      aux_valid = (i < 3); aux_waddr = 5'(25 + i); aux_wdata = 32'h6A0 + 32'(i);
    end
    check("t6_stall_seen", 64'(seen), 64'd1);
    check("t6_lvl_pre", 64'(fifo_level), 64'd3);
    #2;
    idle_inputs();
    chk_addr = 25;
    rst_n = 1'b0;
    #1;
    check("t6_we", 64'(rf_we), 64'd0);
    check("t6_waddr", 64'(rf_waddr), 64'd0);
    check("t6_wdata", 64'(rf_wdata), 64'd0);
    check("t6_stall", 64'(stall_pipe), 64'd0);
    check("t6_lvl", 64'(fifo_level), 64'd0);
    check("t6_pend", 64'(chk_pending), 64'd0);
    check("t6_q", 64'(exp_q.size()), 64'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    check("t6_lvl_after", 64'(fifo_level), 64'd0);
    check("t6_we_after", 64'(rf_we), 64'd0);

    wait_drain(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
